// File: rtl/writeback_top.sv
// Writeback stage: commits retired results to GPR/segment/MMX files or memory.
// Handles push/pop ESP updates and reports retired PCs.
module writeback_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_dest_address,
  input  logic [31:0] wb_dest_reg,
  input  logic [63:0] wb_result,
  input  logic [2:0]  wb_opsize,
  input  logic        wb_op_a_is_address,
  input  logic        wb_op_a_is_reg,
  input  logic        wb_op_a_is_segment,
  input  logic        wb_op_a_is_mmx,
  input  logic [1:0]  wb_stack_op,
  input  logic [31:0] wb_pc,
  input  logic [31:0] esp_in,
  output logic        gpr_we,
  output logic [2:0]  gpr_idx,
  output logic [3:0]  gpr_be,
  output logic [31:0] gpr_data,
  output logic        seg_we,
  output logic [2:0]  seg_idx,
  output logic [15:0] seg_data,
  output logic        mmx_we,
  output logic [2:0]  mmx_idx,
  output logic [63:0] mmx_data,
  output logic        esp_we,
  output logic [31:0] esp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_data,
  output logic [2:0]  mem_size,
  input  logic        mem_done,
  output logic        retire_valid,
  output logic [31:0] retire_pc
);

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  idx;
    logic [63:0] res;
    logic [2:0]  size;
    logic        is_addr;
    logic        is_mmx;
    logic        is_seg;
    logic        is_reg;
    logic [1:0]  stk;
    logic [31:0] pc;
  } hold_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REG_WR   = 2'd1;
  localparam logic [1:0] MEM_REQ  = 2'd2;
  localparam logic [1:0] MEM_WAIT = 2'd3;

  logic [1:0]  state, state_nx;
  hold_t       h;
  logic        accept;
  logic        reg_wr;
  logic [31:0] pop_bytes;
  logic        unused_dest_hi;

  assign unused_dest_hi = ^wb_dest_reg[31:3];

  assign wb_ready = (state == IDLE || state == REG_WR) && !flush;
  assign accept   = wb_valid && wb_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, REG_WR: begin
        if (flush)
          state_nx = IDLE;
        else if (accept)
          state_nx = wb_op_a_is_address ? MEM_REQ : REG_WR;
        else
          state_nx = IDLE;
      end
      MEM_REQ: begin
        if (flush)
          state_nx = IDLE;
        else if (mem_req_ready)
          state_nx = MEM_WAIT;
      end
      MEM_WAIT: begin
        // store already left the stage; flush cannot cancel it
        if (mem_done)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      h     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        h.addr    <= wb_dest_address;
        h.idx     <= wb_dest_reg[2:0];
        h.res     <= wb_result;
        h.size    <= wb_opsize;
        h.is_addr <= wb_op_a_is_address;
        h.is_mmx  <= wb_op_a_is_mmx;
        h.is_seg  <= wb_op_a_is_segment;
        h.is_reg  <= wb_op_a_is_reg;
        h.stk     <= wb_stack_op;
        h.pc      <= wb_pc;
      end
    end
  end

  assign reg_wr = (state == REG_WR) && !flush;

  assign mmx_we = reg_wr && h.is_mmx;
  assign seg_we = reg_wr && h.is_seg && !h.is_mmx;
  assign gpr_we = reg_wr && h.is_reg && !h.is_seg && !h.is_mmx;

  always_comb begin
    gpr_idx  = h.idx;
    gpr_be   = 4'b1111;
    gpr_data = h.res[31:0];
    unique case (1'b1)
      h.size[0]: begin
        if (h.idx[2]) begin
          // AH..BH live in byte 1 of EAX..EBX
          gpr_idx  = {1'b0, h.idx[1:0]};
          gpr_be   = 4'b0010;
          gpr_data = {16'd0, h.res[7:0], 8'd0};
        end else begin
          gpr_be   = 4'b0001;
          gpr_data = {24'd0, h.res[7:0]};
        end
      end
      h.size[1]: begin
        gpr_be   = 4'b0011;
        gpr_data = {16'd0, h.res[15:0]};
      end
      default: ;
    endcase
  end

  assign seg_idx  = h.idx;
  assign seg_data = h.res[15:0];
  assign mmx_idx  = h.idx;
  assign mmx_data = h.res;

  assign retire_valid = reg_wr || (state == MEM_WAIT && mem_done);
  assign retire_pc    = h.pc;

  assign pop_bytes = h.size[0] ? 32'd1 : (h.size[1] ? 32'd2 : 32'd4);

  assign esp_we   = retire_valid && (h.stk == 2'b01 || h.stk == 2'b10);
  assign esp_data = (h.stk == 2'b01) ? h.addr :
                    (h.stk == 2'b10) ? esp_in + pop_bytes : 32'd0;

  assign mem_req_valid = (state == MEM_REQ) && !flush;
  assign mem_addr      = h.addr;
  assign mem_data      = h.res;
  assign mem_size      = h.size;

endmodule

// File: tb/tb_writeback_top.sv
// Scoreboard bench for writeback_top: expected retires queued at drive time,
// checked when retire_valid is seen.
module tb_writeback_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_dest_address;
  logic [31:0] wb_dest_reg;
  logic [63:0] wb_result;
  logic [2:0]  wb_opsize;
  logic        wb_op_a_is_address;
  logic        wb_op_a_is_reg;
  logic        wb_op_a_is_segment;
  logic        wb_op_a_is_mmx;
  logic [1:0]  wb_stack_op;
  logic [31:0] wb_pc;
  logic [31:0] esp_in;
  logic        gpr_we;
  logic [2:0]  gpr_idx;
  logic [3:0]  gpr_be;
  logic [31:0] gpr_data;
  logic        seg_we;
  logic [2:0]  seg_idx;
  logic [15:0] seg_data;
  logic        mmx_we;
  logic [2:0]  mmx_idx;
  logic [63:0] mmx_data;
  logic        esp_we;
  logic [31:0] esp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [2:0]  mem_size;
  logic        mem_done;
  logic        retire_valid;
  logic [31:0] retire_pc;

  writeback_top dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest_address(wb_dest_address), .wb_dest_reg(wb_dest_reg),
    .wb_result(wb_result), .wb_opsize(wb_opsize),
    .wb_op_a_is_address(wb_op_a_is_address),
    .wb_op_a_is_reg(wb_op_a_is_reg),
    .wb_op_a_is_segment(wb_op_a_is_segment),
    .wb_op_a_is_mmx(wb_op_a_is_mmx),
    .wb_stack_op(wb_stack_op), .wb_pc(wb_pc), .esp_in(esp_in),
    .gpr_we(gpr_we), .gpr_idx(gpr_idx), .gpr_be(gpr_be),
    .gpr_data(gpr_data),
    .seg_we(seg_we), .seg_idx(seg_idx), .seg_data(seg_data),
    .mmx_we(mmx_we), .mmx_idx(mmx_idx), .mmx_data(mmx_data),
    .esp_we(esp_we), .esp_data(esp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
    .mem_done(mem_done),
    .retire_valid(retire_valid), .retire_pc(retire_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        gw;
    logic [2:0]  gi;
    logic [3:0]  gb;
    logic [31:0] gd;
    logic        sw;
    logic [2:0]  si;
    logic [15:0] sd;
    logic        mw;
    logic [2:0]  mi;
    logic [63:0] md;
    logic        ew;
    logic [31:0] ed;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_ret = 0;
  int   n_exp = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // cls = {addr, mmx, seg, reg}
  task automatic send(input logic [3:0] cls, input logic [2:0] dreg,
                      input logic [63:0] res, input logic [2:0] sz,
                      input logic [1:0] stk, input logic [31:0] addr,
                      input logic [31:0] pc, input bit exp_ret);
    exp_t e;
    e = '0;
    e.pc = pc;
    if (cls[3]) begin
    end else if (cls[2]) begin
      e.mw = 1'b1; e.mi = dreg; e.md = res;
    end else if (cls[1]) begin
      e.sw = 1'b1; e.si = dreg; e.sd = res[15:0];
    end else if (cls[0]) begin
      e.gw = 1'b1;
      if (sz == 3'b001 && dreg >= 3'd4) begin
        e.gi = dreg - 3'd4; e.gb = 4'b0010;
        e.gd = {16'd0, res[7:0], 8'd0};
      end else if (sz == 3'b001) begin
        e.gi = dreg; e.gb = 4'b0001; e.gd = {24'd0, res[7:0]};
      end else if (sz == 3'b010) begin
        e.gi = dreg; e.gb = 4'b0011; e.gd = {16'd0, res[15:0]};
      end else begin
        e.gi = dreg; e.gb = 4'b1111; e.gd = res[31:0];
      end
    end
    if (stk == 2'b01) begin
      e.ew = 1'b1; e.ed = addr;
    end else if (stk == 2'b10) begin
      e.ew = 1'b1;
      e.ed = esp_in + ((sz == 3'b001) ? 32'd1 : (sz == 3'b010) ? 32'd2 : 32'd4);
    end
    wb_op_a_is_address = cls[3];
    wb_op_a_is_mmx     = cls[2];
    wb_op_a_is_segment = cls[1];
    wb_op_a_is_reg     = cls[0];
    wb_dest_reg        = {29'h1abcdef0, dreg};
    wb_result          = res;
    wb_opsize          = sz;
    wb_stack_op        = stk;
    wb_dest_address    = addr;
    wb_pc              = pc;
    wb_valid           = 1'b1;
    if (exp_ret) begin
      q.push_back(e);
      n_exp++;
    end
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic mem_run(input int rdly, input int ddly,
                         input logic [31:0] a, input logic [63:0] d);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_addr", 64'(mem_addr), 64'(a));
      chk("req_data", mem_data, d);
      chk("req_nrdy", 64'(wb_ready), 64'd0);
      cyc();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", 64'(mem_req_valid), 64'd1);
    chk("req_addr", 64'(mem_addr), 64'(a));
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < ddly; i++) begin
      @(negedge clk);
      chk("wait_noreq", 64'(mem_req_valid), 64'd0);
      chk("wait_nret", 64'(retire_valid), 64'd0);
      chk("wait_nrdy", 64'(wb_ready), 64'd0);
      cyc();
    end
    mem_done = 1'b1;
    @(negedge clk);
    chk("done_nrdy", 64'(wb_ready), 64'd0);
    cyc();
    mem_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("stray_we",
          64'((gpr_we | seg_we | mmx_we | esp_we) & ~retire_valid), 64'd0);
      if (retire_valid) begin
        n_ret++;
        if (q.size() == 0) begin
          chk("retire_unexp", 64'd1, 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("ret_pc", 64'(retire_pc), 64'(mon_e.pc));
          chk("gpr_we", 64'(gpr_we), 64'(mon_e.gw));
          chk("seg_we", 64'(seg_we), 64'(mon_e.sw));
          chk("mmx_we", 64'(mmx_we), 64'(mon_e.mw));
          chk("esp_we", 64'(esp_we), 64'(mon_e.ew));
          if (mon_e.gw) begin
            chk("gpr_idx", 64'(gpr_idx), 64'(mon_e.gi));
            chk("gpr_be", 64'(gpr_be), 64'(mon_e.gb));
            chk("gpr_data", 64'(gpr_data), 64'(mon_e.gd));
          end
          if (mon_e.sw) begin
            chk("seg_idx", 64'(seg_idx), 64'(mon_e.si));
            chk("seg_data", 64'(seg_data), 64'(mon_e.sd));
          end
          if (mon_e.mw) begin
            chk("mmx_idx", 64'(mmx_idx), 64'(mon_e.mi));
            chk("mmx_data", mmx_data, mon_e.md);
          end
          if (mon_e.ew)
            chk("esp_data", 64'(esp_data), 64'(mon_e.ed));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    wb_dest_address = '0; wb_dest_reg = '0; wb_result = '0;
    wb_opsize = 3'b100; wb_op_a_is_address = 1'b0;
    wb_op_a_is_reg = 1'b0; wb_op_a_is_segment = 1'b0;
    wb_op_a_is_mmx = 1'b0; wb_stack_op = 2'b00; wb_pc = '0;
    esp_in = 32'h0000_8000; mem_req_ready = 1'b0; mem_done = 1'b0;

    #12;
    chk("rst_we", 64'({gpr_we, seg_we, mmx_we, esp_we}), 64'd0);
    chk("rst_mreq", 64'(mem_req_valid), 64'd0);
    chk("rst_ret", 64'(retire_valid), 64'd0);
    chk("rst_gdata", 64'(gpr_data), 64'd0);
    chk("rst_mdata", mem_data, 64'd0);
    chk("rst_maddr", 64'(mem_addr), 64'd0);
    chk("rst_esp", 64'(esp_data), 64'd0);
    chk("rst_pc", 64'(retire_pc), 64'd0);
    #10 reset = 1'b1;
    cyc();
    chk("rst_ready", 64'(wb_ready), 64'd1);

    // byte write to CH
    send(4'b0001, 3'd5, 64'hA5, 3'b001, 2'b00, 32'd0, 32'h100, 1'b1);
    @(negedge clk);
    chk("ch_we", 64'(gpr_we), 64'd1);
    cyc();

    // back-to-back dword writes
    for (int i = 0; i < 3; i++) begin
      send(4'b0001, 3'(i), 64'h1111_0000 + 64'(i), 3'b100, 2'b00,
           32'd0, 32'h200 + 32'(4 * i), 1'b1);
      @(negedge clk);
      chk("b2b_we", 64'(gpr_we), 64'd1);
      chk("b2b_rdy", 64'(wb_ready), 64'd1);
    end
    cyc();
    chk("b2b_cnt", 64'(n_ret), 64'd4);

    // byte low, word, segment, mmx, priority, no-destination
    send(4'b0001, 3'd2, 64'h77FF, 3'b001, 2'b00, 32'd0, 32'h300, 1'b1);
    send(4'b0001, 3'd6, 64'hCAFE_BEEF, 3'b010, 2'b00, 32'd0, 32'h304, 1'b1);
    send(4'b0010, 3'd3, 64'h1234_5678, 3'b010, 2'b00, 32'd0, 32'h308, 1'b1);
    send(4'b0100, 3'd6, 64'h0123_4567_89AB_CDEF, 3'b100, 2'b00, 32'd0,
         32'h30C, 1'b1);
    send(4'b0111, 3'd1, 64'hFEDC_BA98_7654_3210, 3'b100, 2'b00, 32'd0,
         32'h310, 1'b1);
    send(4'b0011, 3'd4, 64'h5555_AAAA, 3'b010, 2'b00, 32'd0, 32'h314, 1'b1);
    send(4'b0000, 3'd0, 64'h9999, 3'b100, 2'b00, 32'd0, 32'h318, 1'b1);
    cyc();
    chk("mix_cnt", 64'(n_ret), 64'd11);

    // store with backpressure
    send(4'b1000, 3'd0, 64'hDEAD_BEEF, 3'b100, 2'b00, 32'h1000,
         32'h400, 1'b1);
    chk("st_size", 64'(mem_size), 64'(3'b100));
    mem_run(2, 2, 32'h1000, 64'hDEAD_BEEF);
    chk("st_cnt", 64'(n_ret), 64'd12);
    chk("st_rdy", 64'(wb_ready), 64'd1);

    // push then pop word into EAX
    send(4'b1000, 3'd0, 64'h42, 3'b100, 2'b01, 32'h7FFC, 32'h500, 1'b1);
    mem_run(0, 0, 32'h7FFC, 64'h42);
    esp_in = 32'h7FFC;
    send(4'b0001, 3'd0, 64'hABCD_1234, 3'b010, 2'b10, 32'd0, 32'h504, 1'b1);
    @(negedge clk);
    chk("pop_esp", 64'(esp_data), 64'h7FFE);
    cyc();
    chk("pp_cnt", 64'(n_ret), 64'd14);

    // flush during REG_WR suppresses the write
    send(4'b0001, 3'd3, 64'h1, 3'b100, 2'b00, 32'd0, 32'h600, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_reg_we", 64'(gpr_we), 64'd0);
    chk("fl_reg_ret", 64'(retire_valid), 64'd0);
    chk("fl_reg_rdy", 64'(wb_ready), 64'd0);
    cyc();
    flush = 1'b0;

    // flush in MEM_REQ drops the store
    send(4'b1000, 3'd0, 64'h77, 3'b100, 2'b00, 32'h2000, 32'h700, 1'b0);
    flush = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("fl_req_v", 64'(mem_req_valid), 64'd0);
    chk("fl_req_ret", 64'(retire_valid), 64'd0);
    cyc();
    flush = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("fl_req_idle", 64'(wb_ready), 64'd1);
    chk("fl_req_nv", 64'(mem_req_valid), 64'd0);
    cyc();

    // flush in MEM_WAIT is ignored
    send(4'b1000, 3'd0, 64'h88, 3'b100, 2'b00, 32'h3000, 32'h800, 1'b1);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_wt_ret", 64'(retire_valid), 64'd0);
    cyc();
    mem_done = 1'b1;
    @(negedge clk);
    chk("fl_wt_ret2", 64'(retire_valid), 64'd1);
    cyc();
    mem_done = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_wt_rdy", 64'(wb_ready), 64'd1);
    chk("fl_wt_cnt", 64'(n_ret), 64'd15);
    cyc();

    // async reset while waiting on memory
    send(4'b1000, 3'd0, 64'h99, 3'b100, 2'b00, 32'h4000, 32'h900, 1'b0);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_ret", 64'(retire_valid), 64'd0);
    chk("ar_addr", 64'(mem_addr), 64'd0);
    chk("ar_data", mem_data, 64'd0);
    chk("ar_pc", 64'(retire_pc), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("ar_rdy", 64'(wb_ready), 64'd1);
    mem_done = 1'b1;
    @(negedge clk);
    chk("ar_noret", 64'(retire_valid), 64'd0);
    cyc();
    mem_done = 1'b0;
    cyc();

    chk("q_empty", 64'(q.size()), 64'd0);
    chk("ret_total", 64'(n_ret), 64'(n_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
